ps2_host_tx: RTL

- PS/2 host-to-device transmitter; sends one command byte to the keyboard, e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset.
- Complements the existing PS/2 receive path.
- Drives the bidirectional ps2_clock/ps2_data pads through open-drain enables. The top level ties each pad low when its enable is 1, else high-Z.
- Reports the device ACK, a missing ACK, or a timeout.

---
 rtl/ps2_host_tx_if.sv | 21 ++
 rtl/ps2_host_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx_if.sv
// Command-side bus of the PS/2 host transmitter: byte handshake plus status pulses.
// The client drives the master side; ps2_host_tx sits on the slave side.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       busy;
    logic       tx_done;
    logic       tx_ack_err;
    logic       tx_timeout;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, busy, tx_done, tx_ack_err, tx_timeout
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, busy, tx_done, tx_ack_err, tx_timeout
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clock out one byte
// under device clocking, then report ACK / NACK / timeout as a single pulse.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic          clock,
    input  logic          resetn,
    ps2_host_tx_if.slave  bus,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          ps2_clk_oe,
    output logic          ps2_dat_oe
);

    localparam int MAX_A = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int MAX_C = (MAX_A > SETUP_CYCLES) ? MAX_A : SETUP_CYCLES;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] SU_LAST  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    edge_n;
    logic [7:0]    data_q;
    logic          par_q;
    logic          ack_q;
    logic          clk_s1, clk_s2, clk_s3;
    logic          dat_s1, dat_s2;
    logic          ready_q, busy_q, done_q, nack_q, tmo_q;
    logic          clk_oe_q, dat_oe_q;
    logic          fall;
    logic          timeout_hit;

    assign fall        = clk_s3 & ~clk_s2;
    assign timeout_hit = ((state == S_SEND) || (state == S_WAIT_IDLE)) && (cnt == TO_LAST);

    assign bus.tx_ready   = ready_q;
    assign bus.busy       = busy_q;
    assign bus.tx_done    = done_q;
    assign bus.tx_ack_err = nack_q;
    assign bus.tx_timeout = tmo_q;
    assign ps2_clk_oe     = clk_oe_q;
    assign ps2_dat_oe     = dat_oe_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= S_IDLE;
            cnt      <= '0;
            edge_n   <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            ack_q    <= 1'b0;
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_s3   <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            nack_q   <= 1'b0;
            tmo_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
        end else begin
            clk_s1 <= ps2_clk_in;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_dat_in;
            dat_s2 <= dat_s1;
            done_q <= 1'b0;
            nack_q <= 1'b0;
            tmo_q  <= 1'b0;

            case (state)
                S_IDLE: begin
                    // One idle cycle with ready low after every transfer, then accept.
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (bus.tx_valid) begin
                        data_q   <= bus.tx_data;
                        par_q    <= ~^bus.tx_data;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        clk_oe_q <= 1'b1;
                        dat_oe_q <= 1'b0;
                        cnt      <= '0;
                        edge_n   <= '0;
                        state    <= S_INHIBIT;
                    end
                end

                S_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt      <= '0;
                        dat_oe_q <= 1'b1;
                        state    <= S_REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_REQ: begin
                    if (cnt == SU_LAST) begin
                        cnt      <= '0;
                        clk_oe_q <= 1'b0;
                        state    <= S_SEND;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_SEND: begin
                    if (timeout_hit) begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b0;
                        tmo_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        cnt      <= '0;
                        state    <= S_IDLE;
                    end else begin
                        // Not cleared on entering WAIT_IDLE: the timeout spans both states.
                        cnt <= cnt + 1'b1;
                        if (fall) begin
                            edge_n <= (edge_n == 4'd11) ? 4'd11 : edge_n + 4'd1;
                            case (edge_n)
                                4'd0, 4'd1, 4'd2, 4'd3,
                                4'd4, 4'd5, 4'd6, 4'd7: dat_oe_q <= ~data_q[edge_n[2:0]];
                                4'd8:  dat_oe_q <= ~par_q;
                                4'd9:  dat_oe_q <= 1'b0;
                                4'd10: begin
                                    ack_q <= ~dat_s2;
                                    state <= S_WAIT_IDLE;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                S_WAIT_IDLE: begin
                    if (timeout_hit) begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b0;
                        tmo_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        cnt      <= '0;
                        state    <= S_IDLE;
                    end else if (clk_s2 && dat_s2) begin
                        done_q <= ack_q;
                        nack_q <= ~ack_q;
                        busy_q <= 1'b0;
                        cnt    <= '0;
                        state  <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    clk_oe_q <= 1'b0;
                    dat_oe_q <= 1'b0;
                    busy_q   <= 1'b0;
                    cnt      <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
